intr_rq_ctl: RTL and testbench

// - Synchronous controller for channel/CPU interrupt-report cycles on the system bus (IN cycle).
// - Sequences the delay/sample/acknowledge window and decides accept or reject.
// - Emits one-cycle request pulses to the interrupt request register: zk[0:15], rz4, rz29.
// - Drives the dok response; replaces the dly/univib timing pair with counted cycles.

---
 rtl/intr_rq_ctl.sv | 156 +++++++++++++++
 tb/tb_intr_rq_ctl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/intr_rq_ctl.sv
// Interrupt-report (IN cycle) controller: delay/sample/acknowledge sequencing with one-cycle request pulses.
// Optional INTR_RQ_STATS_EN adds saturating accept/reject counters.
module intr_rq_ctl #(
    parameter int unsigned DOK_DLY_TICKS = 3,
    parameter int unsigned DOK_TICKS     = 8,
    parameter int unsigned TMO_TICKS     = 255
) (
    input  logic        __clk,
    input  logic        clm,
    input  logic        rin,
    input  logic        zw,
    input  logic        zgpn_,
    input  logic [0:15] rdt,
    output logic        dok,
    output logic [0:15] zk,
    output logic        rz4,
    output logic        rz29,
    output logic        busy,
    output logic        to_err
`ifdef INTR_RQ_STATS_EN
    ,
    output logic [0:15] acc_cnt,
    output logic [0:15] rej_cnt
`endif
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] DLY_INIT = CNT_W'(DOK_DLY_TICKS - 1);
    localparam logic [CNT_W-1:0] DOK_INIT = CNT_W'(DOK_TICKS - 1);
    localparam logic [CNT_W-1:0] TMO_INIT = CNT_W'(TMO_TICKS - 1);

    typedef enum logic [2:0] {IDLE, DLY, SAMP, ACK, WREL} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             acc;
    logic             need_rel;

    logic             accept;
    logic             dec_rz4;
    logic             dec_rz29;
    logic [0:15]      dec_zk;
    logic [3:0]       ch;
    logic             unused_rdt;

    // rdt[1:10] carry no meaning for the report decision
    assign unused_rdt = ^rdt[1:10];

    // Report decode: CPU reports always accepted, channel reports only when group enabled
    always_comb begin
        accept   = 1'b0;
        dec_rz4  = 1'b0;
        dec_rz29 = 1'b0;
        dec_zk   = '0;
        ch       = rdt[11:14];
        if (rdt[15]) begin
            accept   = 1'b1;
            dec_rz29 = rdt[0];
            dec_rz4  = !rdt[0];
        end else if (zgpn_) begin
            accept     = 1'b1;
            dec_zk[ch] = 1'b1;
        end
    end

    always_ff @(posedge __clk) begin
        if (clm) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= 1'b0;
            need_rel <= 1'b0;
            dok      <= 1'b0;
            zk       <= '0;
            rz4      <= 1'b0;
            rz29     <= 1'b0;
            busy     <= 1'b0;
            to_err   <= 1'b0;
`ifdef INTR_RQ_STATS_EN
            acc_cnt  <= '0;
            rej_cnt  <= '0;
`endif
        end else begin
            zk     <= '0;
            rz4    <= 1'b0;
            rz29   <= 1'b0;
            to_err <= 1'b0;
            if (!rin) need_rel <= 1'b0;
            case (state)
                IDLE: begin
                    if (rin && !zw && !need_rel) begin
                        state <= DLY;
                        cnt   <= DLY_INIT;
                        busy  <= 1'b1;
                    end
                end
                DLY: begin
                    if (!rin || zw) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == '0) begin
                        state <= SAMP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                SAMP: begin
                    state <= ACK;
                    cnt   <= DOK_INIT;
                    acc   <= accept;
                    dok   <= accept && rin;
                    zk    <= dec_zk;
                    rz4   <= dec_rz4;
                    rz29  <= dec_rz29;
`ifdef INTR_RQ_STATS_EN
                    if (accept && acc_cnt != 16'hffff) acc_cnt <= acc_cnt + 16'd1;
                    if (!accept && rej_cnt != 16'hffff) rej_cnt <= rej_cnt + 16'd1;
`endif
                end
                ACK: begin
                    if (!rin) begin
                        state <= IDLE;
                        dok   <= 1'b0;
                        busy  <= 1'b0;
                    end else if (cnt == '0) begin
                        state <= WREL;
                        dok   <= 1'b0;
                        cnt   <= TMO_INIT;
                    end else begin
                        dok <= acc;
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                WREL: begin
                    if (!rin) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == '0) begin
                        // held rin must drop before the next report is taken
                        state    <= IDLE;
                        busy     <= 1'b0;
                        to_err   <= 1'b1;
                        need_rel <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    dok   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intr_rq_ctl.sv
// Self-checking bench for intr_rq_ctl: directed and randomized report cycles against a closed-form timing model.
module tb_intr_rq_ctl;

    localparam int D     = 3;
    localparam int DOK   = 8;
    localparam int TMO   = 255;
    localparam int T_END = D + 1 + DOK + TMO;
    localparam int NONE  = 100000;

    typedef struct packed {
        logic [0:15] zk;
        logic        rz4;
        logic        rz29;
        logic        dok;
        logic        busy;
        logic        to_err;
    } obs_t;

    logic        clk = 1'b0;
    logic        clm, rin, zw, zgpn_;
    logic [0:15] rdt;
    logic        dok, rz4, rz29, busy, to_err;
    logic [0:15] zk;
`ifdef INTR_RQ_STATS_EN
    logic [0:15] acc_cnt, rej_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    intr_rq_ctl #(.DOK_DLY_TICKS(D), .DOK_TICKS(DOK), .TMO_TICKS(TMO)) dut (
        .__clk(clk), .clm(clm), .rin(rin), .zw(zw), .zgpn_(zgpn_), .rdt(rdt),
        .dok(dok), .zk(zk), .rz4(rz4), .rz29(rz29), .busy(busy), .to_err(to_err)
`ifdef INTR_RQ_STATS_EN
        , .acc_cnt(acc_cnt), .rej_cnt(rej_cnt)
`endif
    );

    // Expected outputs after edge k of a report: rin high for edges 0..len-1, zw high from edge z while rin high
    function automatic obs_t model(int k, int len, int z, logic [15:0] v, logic g);
        obs_t e;
        bit   abort, cpu, acc;
        int   idle_e, ch;
        e      = '0;
        cpu    = v[0];
        acc    = cpu || g;
        ch     = int'((v >> 1) & 16'h000f);
        abort  = (len <= D) || (z <= D);
        if (abort)                  idle_e = (len < z) ? len : z;
        else if (len <= D + 1 + DOK) idle_e = (len > D + 2) ? len : D + 2;
        else if (len <= T_END)      idle_e = len;
        else                        idle_e = T_END;
        e.busy = (k < idle_e);
        if (!abort) begin
            if (k == D + 1) begin
                if (cpu) begin
                    e.rz29 = v[15];
                    e.rz4  = !v[15];
                end else if (g) begin
                    e.zk = 16'h8000 >> ch;
                end
            end
            e.dok    = acc && (k >= D + 1) && (k <= D + DOK) && (k < len);
            e.to_err = (len > T_END) && (k == T_END);
        end
        return e;
    endfunction

    task automatic apply(int k, int len, int z, logic [15:0] v, logic g);
        @(negedge clk);
        rin   = (k < len);
        zw    = (k < len) && (k >= z);
        rdt   = v;
        zgpn_ = g;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clm = 1'b1; rin = 1'b1; zw = 1'b0; zgpn_ = 1'b1; rdt = 16'h0018;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({zk, rz4, rz29, dok, busy, to_err} !== 21'h0) begin
            errors++;
            $display("FAIL reset outputs got %h exp 0", {zk, rz4, rz29, dok, busy, to_err});
        end
        @(negedge clk);
        clm = 1'b0; rin = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_directed();
        int          lens[7]  = '{20, 20, 20, 20, 2, 10, 300};
        int          zs[7]    = '{NONE, NONE, NONE, NONE, NONE, 0, NONE};
        logic [15:0] vals[7]  = '{16'h0018, 16'h8001, 16'h0001, 16'h0010, 16'h0018, 16'h0018, 16'h0018};
        logic        gs[7]    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        string       names[7] = '{"channel", "cpu_low", "cpu_high", "reject", "glitch", "own_cycle", "timeout"};
        obs_t        obs, exp_o;
        for (int t = 0; t < 7; t++) begin
            for (int k = 0; k < ((lens[t] > D + 3) ? lens[t] : D + 3) + 3; k++) begin
                apply(k, lens[t], zs[t], vals[t], gs[t]);
                obs   = {zk, rz4, rz29, dok, busy, to_err};
                exp_o = model(k, lens[t], zs[t], vals[t], gs[t]);
                checks++;
                if (obs !== exp_o) begin
                    errors++;
                    $display("FAIL %s k=%0d got %h exp %h", names[t], k, obs, exp_o);
                end
            end
        end
    endtask

    task automatic test_clm_abort();
        int   ces[2] = '{D + 1, D + 3};
        obs_t obs, exp_o;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < ces[i]; k++) begin
                apply(k, 20, NONE, 16'h0018, 1'b1);
                obs   = {zk, rz4, rz29, dok, busy, to_err};
                exp_o = model(k, 20, NONE, 16'h0018, 1'b1);
                checks++;
                if (obs !== exp_o) begin
                    errors++;
                    $display("FAIL clm_pre ce=%0d k=%0d got %h exp %h", ces[i], k, obs, exp_o);
                end
            end
            @(negedge clk);
            clm = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if ({zk, rz4, rz29, dok, busy, to_err} !== 21'h0) begin
                errors++;
                $display("FAIL clm_abort ce=%0d got %h exp 0", ces[i], {zk, rz4, rz29, dok, busy, to_err});
            end
`ifdef INTR_RQ_STATS_EN
            checks++;
            if ({acc_cnt, rej_cnt} !== 32'h0) begin
                errors++;
                $display("FAIL clm_stats got %h exp 0", {acc_cnt, rej_cnt});
            end
`endif
            @(negedge clk);
            clm = 1'b0;
            rin = 1'b0;
            @(posedge clk);
            #1;
            checks++;
            if ({zk, rz4, rz29, dok, busy, to_err} !== 21'h0) begin
                errors++;
                $display("FAIL clm_after ce=%0d got %h exp 0", ces[i], {zk, rz4, rz29, dok, busy, to_err});
            end
        end
    endtask

    task automatic test_random();
        obs_t        obs, exp_o;
        int          len, z, kmax;
        logic [15:0] v;
        logic        g;
        for (int n = 0; n < 40; n++) begin
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(T_END - 5, T_END + 20))
                                              : int'($urandom_range(0, 30));
            z   = ($urandom_range(0, 1) == 0) ? NONE : int'($urandom_range(0, D + 3));
            v   = 16'($urandom);
            g   = 1'($urandom_range(0, 1));
            kmax = ((len > D + 3) ? len : D + 3) + 3;
            for (int k = 0; k < kmax; k++) begin
                apply(k, len, z, v, g);
                obs   = {zk, rz4, rz29, dok, busy, to_err};
                exp_o = model(k, len, z, v, g);
                checks++;
                if (obs !== exp_o) begin
                    errors++;
                    $display("FAIL random n=%0d len=%0d z=%0d v=%h g=%0d k=%0d got %h exp %h",
                             n, len, z, v, g, k, obs, exp_o);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_clm_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
